// File: rtl/tl_sensor_cond.sv
// Traffic-sensor conditioner: per-street sync, debounce, gap-hold
// and saturating arrival counting feeding the light controller.
module tl_sensor_chan #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw,
  input  logic             clr,
  output logic             t,
  output logic             ev,
  output logic [CNT_W-1:0] cnt
);

  localparam int MAXC = (DEB_CYCLES > HOLD_CYCLES) ?
                        DEB_CYCLES : HOLD_CYCLES;
  localparam int RW = $clog2(MAXC + 1);

  // bit 1 of the state code is the traffic-present flag
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] QUAL = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  localparam logic [RW-1:0] DEB_L  = RW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_L = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] ONE    = RW'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic          s1;
  logic          s;
  logic [1:0]    state;
  logic [1:0]    nstate;
  logic [RW-1:0] run;
  logic [RW-1:0] nrun;
  logic          arr;

  always_comb begin
    nstate = state;
    nrun   = run;
    arr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          if (DEB_CYCLES == 1) begin
            nstate = BUSY;
            nrun   = '0;
            arr    = 1'b1;
          end else begin
            nstate = QUAL;
            nrun   = ONE;
          end
        end
      end
      QUAL: begin
        if (!s) begin
          nstate = IDLE;
          nrun   = '0;
        end else if (run == DEB_L) begin
          nstate = BUSY;
          nrun   = '0;
          arr    = 1'b1;
        end else begin
          nrun = run + ONE;
        end
      end
      BUSY: begin
        if (!s) begin
          if (HOLD_CYCLES == 1) begin
            nstate = IDLE;
            nrun   = '0;
          end else begin
            nstate = GAP;
            nrun   = ONE;
          end
        end
      end
      GAP: begin
        if (s) begin
          nstate = BUSY;
          nrun   = '0;
        end else if (run == HOLD_L) begin
          nstate = IDLE;
          nrun   = '0;
        end else begin
          nrun = run + ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      run   <= '0;
      t     <= 1'b0;
      ev    <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s     <= s1;
      state <= nstate;
      run   <= nrun;
      t     <= nstate[1];
      ev    <= arr;
      if (arr) begin
        if (clr)
          cnt <= CNT_W'(1);
        else if (cnt != CMAX)
          cnt <= cnt + CNT_W'(1);
      end else if (clr) begin
        cnt <= '0;
      end
    end
  end

endmodule

module tl_sensor_cond #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sa_raw,
  input  logic             sb_raw,
  input  logic             clr_cnt,
  output logic             Ta,
  output logic             Tb,
  output logic             ev_a,
  output logic             ev_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  tl_sensor_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_a (
    .clk  (clk),
    .reset(reset),
    .raw  (sa_raw),
    .clr  (clr_cnt),
    .t    (Ta),
    .ev   (ev_a),
    .cnt  (cnt_a)
  );

  tl_sensor_chan #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_b (
    .clk  (clk),
    .reset(reset),
    .raw  (sb_raw),
    .clr  (clr_cnt),
    .t    (Tb),
    .ev   (ev_b),
    .cnt  (cnt_b)
  );

endmodule

// File: doc/tl_sensor_cond.md
# tl_sensor_cond

Traffic-sensor conditioner sitting directly upstream of the traffic-light controller. Takes the two raw, asynchronous, bouncy car-detector lines for street A and street B and produces the clean registered Ta/Tb traffic-present inputs the controller consumes. Per street: synchronizes the input, qualifies it with a debounce window, and stretches it with a gap-hold timer. Also pulses and counts each qualified car arrival.

## Interface
- DEB_CYCLES, 4: consecutive sampled-high cycles needed to qualify traffic (≥1)
- HOLD_CYCLES, 8: consecutive sampled-low cycles needed to drop traffic (≥1)
- CNT_W, 8: width of the arrival counters
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- sa_raw  in  1  raw street-A detector, asynchronous to clk
- sb_raw  in  1  raw street-B detector, asynchronous to clk
- clr_cnt  in  1  synchronous clear of both arrival counters
- Ta  out  1  conditioned street-A traffic present (to controller)
- Tb  out  1  conditioned street-B traffic present (to controller)
- ev_a  out  1  one-cycle pulse on qualified street-A arrival
- ev_b  out  1  one-cycle pulse on qualified street-B arrival
- cnt_a  out  CNT_W  street-A arrival count, saturating
- cnt_b  out  CNT_W  street-B arrival count, saturating

## Operation
- Two identical, independent channels (A, B); no interaction except the shared clr_cnt.
- Sync: raw → 2-flop synchronizer → s. Both flops reset to 0.
- Per-channel FSM; the run counter is the width needed for max(DEB_CYCLES, HOLD_CYCLES).
  - IDLE (T=0): s=1 → QUAL with run=1; if DEB_CYCLES=1, go straight to BUSY as an arrival.
  - QUAL (T=0): s=0 → IDLE, run=0. s=1 and run=DEB_CYCLES-1 → BUSY as an arrival. Otherwise run++.
  - BUSY (T=1): s=0 → GAP with run=1; if HOLD_CYCLES=1, go straight to IDLE (T=0).
  - GAP (T=1): s=1 → BUSY, with no arrival and no count. s=0 and run=HOLD_CYCLES-1 → IDLE (T=0). Otherwise run++.
- Arrival (entry to BUSY from IDLE/QUAL only):
  - ev pulses high for exactly one cycle.
  - cnt increments by 1, saturating at 2^CNT_W-1; no wrap.
- Effect of clr_cnt=1 on a given edge:
  - No arrival on the same edge: both counters go to 0.
  - Arrival on the same edge: that channel's counter goes to 1; the other channel goes to 0.
- T, ev, cnt are registered outputs; no combinational path from inputs.
- Reset values: FSM=IDLE, run=0, sync flops=0, Ta=Tb=0, ev_a=ev_b=0, cnt_a=cnt_b=0.
- Reset asserted mid-operation (any state): all of the above return to reset values asynchronously. After release, a still-high raw input must requalify from scratch.

## Timing
- Sync latency: 2 edges from raw change to s.
- Rise: raw held high from before edge 0 → s=1 sampled at edges 3..3+DEB_CYCLES-1.
  - T and ev assert after edge DEB_CYCLES+2 (defaults: edge 6). cnt updates on the same edge.
- Fall: raw held low from before edge 0 (channel in BUSY) → T deasserts after edge HOLD_CYCLES+2 (defaults: edge 10).
- Glitch rejection: a high pulse sampled for fewer than DEB_CYCLES consecutive edges never asserts T.
- Gap bridging: a low dropout sampled for fewer than HOLD_CYCLES consecutive edges never deasserts T and causes no new ev or count.
- Back-to-back cars: next arrival is possible only after the channel returns to IDLE. Minimum spacing between ev pulses is HOLD_CYCLES+DEB_CYCLES edges.
- Ta and Tb may assert and deassert on the same edge; channels are fully independent.

## Test plan
- Reset: assert reset mid-cycle with sa_raw=1 in BUSY and cnt_a=5 → Ta=0, ev_a=0, cnt_a=0 immediately (no clock edge). After release with sa_raw still 1 → Ta rises after edge 6 and cnt_a=1.
- Debounce: sa_raw high for 3 clocks then low (defaults) → Ta, ev_a, cnt_a stay 0. sa_raw high steadily → Ta=1 and ev_a one-cycle pulse after edge 6, cnt_a=1.
- Gap hold: Ta=1, sa_raw low 5 clocks then high → Ta stays 1, no ev_a, cnt_a unchanged. Then sa_raw low steadily → Ta=0 after edge 10 from the fall.
- Saturation/clear with CNT_W=2: drive 5 qualified cars → cnt_a 1,2,3,3,3. Pulse clr_cnt on the same edge as an arrival → cnt_a=1 and cnt_b=0.
- Independence: staggered identical traffic on sa_raw and sb_raw offset by 3 clocks → Tb and ev_b reproduce Ta and ev_a exactly, offset by 3 clocks. Simultaneous stimulus → Ta and Tb toggle on the same edge.
- Edge parameters DEB_CYCLES=1, HOLD_CYCLES=1: single-cycle raw pulse wide enough to be sampled → Ta high for exactly one cycle after edge 3, ev_a one pulse, cnt_a=1.
